// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control slice: controller and CPU FSM
// state encodings, status flag bit positions and the default idle timeout.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQ        = 3'd1,
    ST_SERVICE    = 3'd2,
    ST_SLEEP_PEND = 3'd3,
    ST_SLEEP      = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CPU_RUN   = 2'd0,
    CPU_IRQ   = 2'd1,
    CPU_SLEEP = 2'd2,
    CPU_WAKE  = 2'd3
  } cpu_state_t;

  localparam int STAT_IRQ_BIT   = 0;
  localparam int STAT_BUSY_BIT  = 1;
  localparam int STAT_SLEEP_BIT = 2;
  localparam int STAT_WAKE_BIT  = 3;

  localparam int DEF_IDLE_TIMEOUT = 16;

endpackage

// File: rtl/irq_prio_arbiter.sv
// Combinational priority arbiter: scans the request vector starting at
// index 'start' and wrapping, granting the first set bit it meets.
// A start of zero gives plain lowest-index-wins priority.
module irq_prio_arbiter #(
  parameter int N_IRQ = 4,
  parameter int VEC_W = 2
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [VEC_W-1:0] start,
  output logic             gnt_vld,
  output logic [VEC_W-1:0] gnt_idx
);

  int idx;

  // Wrapping first-set-bit search from the start pointer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N_IRQ; i++) begin
      idx = (int'(start) + i) % N_IRQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[VEC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cpu_irq_sleep_ctrl.sv
// Interrupt and power sequencer for the CPU control FSM.
// Captures rising edges on irq_in into a pending register, arbitrates the
// unmasked pending sources and hands one vector at a time to the CPU over
// irq_req/irq_ack/irq_done. Requests CPU sleep after IDLE_TIMEOUT idle
// cycles and requests wakeup while an unmasked interrupt is pending.
// Optional build macro IRQ_ROUND_ROBIN_EN: rotating priority starting after
// the last acknowledged vector; without it, lowest index always wins.
module cpu_irq_sleep_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int N_IRQ        = 4,
  parameter int VEC_W        = 2,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             irq_mask_we,
  input  logic [N_IRQ-1:0] irq_mask_wdata,
  input  logic             cpu_asleep,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic [N_IRQ-1:0] irq_pending,
  output logic             busy,
  output logic             sleep_request,
  output logic             wakeup_request
);

  localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  ctrl_state_t      state;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] irq_mask;
  logic [CNT_W-1:0] idle_cnt;
  logic [VEC_W-1:0] rr_ptr;
  logic             gnt_vld;
  logic [VEC_W-1:0] gnt_idx;
  logic             ack_take;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] irq_edge;

  assign irq_edge = irq_in & ~irq_prev;
  assign ack_take = (state == ST_REQ) && irq_ack;
  assign ack_clr  = ack_take ? (N_IRQ'(1) << irq_vec) : '0;

  irq_prio_arbiter #(
    .N_IRQ (N_IRQ),
    .VEC_W (VEC_W)
  ) u_arb (
    .req     (irq_pending & irq_mask),
    .start   (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Edge capture into pending; a new edge beats an acknowledge clear
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev    <= '0;
      irq_pending <= '0;
    end else begin
      irq_prev    <= irq_in;
      irq_pending <= (irq_pending & ~ack_clr) | irq_edge;
    end
  end

  // Enable mask, all sources enabled out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '1;
    end else if (irq_mask_we) begin
      irq_mask <= irq_mask_wdata;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  // Rotating search start: one past the vector the CPU last accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (ack_take) begin
      if (int'(irq_vec) == N_IRQ - 1) rr_ptr <= '0;
      else                            rr_ptr <= irq_vec + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // Controller FSM with registered handshake and power outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      idle_cnt       <= '0;
      irq_req        <= 1'b0;
      irq_vec        <= '0;
      busy           <= 1'b0;
      sleep_request  <= 1'b0;
      wakeup_request <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            state    <= ST_REQ;
            irq_req  <= 1'b1;
            irq_vec  <= gnt_idx;
            idle_cnt <= '0;
          end else if ((IDLE_TIMEOUT != 0) && (int'(idle_cnt) == IDLE_TIMEOUT - 1)) begin
            state         <= ST_SLEEP_PEND;
            sleep_request <= 1'b1;
            idle_cnt      <= '0;
          end else if (int'(idle_cnt) < IDLE_TIMEOUT - 1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        // The latched vector stays presented until the CPU accepts it
        ST_REQ: begin
          if (irq_ack) begin
            state   <= ST_SERVICE;
            irq_req <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (irq_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        // A pending interrupt aborts the sleep even if the CPU just slept
        ST_SLEEP_PEND: begin
          if (gnt_vld) begin
            state         <= ST_IDLE;
            sleep_request <= 1'b0;
          end else if (cpu_asleep) begin
            state         <= ST_SLEEP;
            sleep_request <= 1'b0;
          end
        end
        ST_SLEEP: begin
          if (!cpu_asleep) begin
            state          <= ST_IDLE;
            wakeup_request <= 1'b0;
          end else begin
            wakeup_request <= gnt_vld;
          end
        end
        default: begin
          state          <= ST_IDLE;
          irq_req        <= 1'b0;
          busy           <= 1'b0;
          sleep_request  <= 1'b0;
          wakeup_request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_irq_sleep_ctrl.sv
// Directed bench for cpu_irq_sleep_ctrl (N_IRQ=4, IDLE_TIMEOUT=16).
module tb_cpu_irq_sleep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       irq_mask_we;
  logic [3:0] irq_mask_wdata;
  logic       cpu_asleep;
  logic       irq_ack;
  logic       irq_done;
  logic       irq_req;
  logic [1:0] irq_vec;
  logic [3:0] irq_pending;
  logic       busy;
  logic       sleep_request;
  logic       wakeup_request;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cpu_irq_sleep_ctrl #(
    .N_IRQ        (4),
    .VEC_W        (2),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_in         (irq_in),
    .irq_mask_we    (irq_mask_we),
    .irq_mask_wdata (irq_mask_wdata),
    .cpu_asleep     (cpu_asleep),
    .irq_ack        (irq_ack),
    .irq_done       (irq_done),
    .irq_req        (irq_req),
    .irq_vec        (irq_vec),
    .irq_pending    (irq_pending),
    .busy           (busy),
    .sleep_request  (sleep_request),
    .wakeup_request (wakeup_request)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_in = '0; irq_mask_we = 1'b0; irq_mask_wdata = '0;
    cpu_asleep = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic serve();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({irq_req, irq_vec, irq_pending, busy, sleep_request, wakeup_request} !== 10'b0)
      $display("FAIL reset_outputs: got %b want 0", {irq_req, irq_vec, irq_pending, busy, sleep_request, wakeup_request});
    else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    irq_in = 4'b0100; tick();
    n_total++;
    if (irq_pending !== 4'b0100 || irq_req !== 1'b0)
      $display("FAIL basic_pend: pending=%b req=%b want 0100/0", irq_pending, irq_req);
    else n_pass++;
    tick();
    n_total++;
    if (irq_req !== 1'b1 || irq_vec !== 2'd2)
      $display("FAIL basic_req: req=%b vec=%0d want 1/2", irq_req, irq_vec);
    else n_pass++;
    // stray done in REQ and masking the latched source keep the request
    irq_done = 1'b1; irq_mask_we = 1'b1; irq_mask_wdata = 4'b1011; tick();
    irq_done = 1'b0; irq_mask_we = 1'b0; tick();
    n_total++;
    if (irq_req !== 1'b1 || irq_vec !== 2'd2 || busy !== 1'b0)
      $display("FAIL basic_hold: req=%b vec=%0d busy=%b want 1/2/0", irq_req, irq_vec, busy);
    else n_pass++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_total++;
    if (irq_pending !== 4'b0000 || busy !== 1'b1 || irq_req !== 1'b0)
      $display("FAIL basic_ack: pending=%b busy=%b req=%b want 0000/1/0", irq_pending, busy, irq_req);
    else n_pass++;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL basic_done: busy=%b want 0", busy);
    else n_pass++;
    irq_in = '0;
  endtask

  task automatic test_priority();
    logic [1:0] exp_vec;
    do_reset();
    irq_in = 4'b1010; tick(); irq_in = '0; tick();
    n_total++;
    if (irq_req !== 1'b1 || irq_vec !== 2'd1)
      $display("FAIL prio_first: req=%b vec=%0d want 1/1", irq_req, irq_vec);
    else n_pass++;
    serve(); tick();
    n_total++;
    if (irq_req !== 1'b1 || irq_vec !== 2'd3)
      $display("FAIL prio_second: req=%b vec=%0d want 1/3", irq_req, irq_vec);
    else n_pass++;
    serve();
    // last grant was 3; now grant 1 then race sources 0 and 3
    irq_in = 4'b0010; tick(); irq_in = '0; tick(); serve();
    irq_in = 4'b1001; tick(); irq_in = '0; tick();
`ifdef IRQ_ROUND_ROBIN_EN
    exp_vec = 2'd3;
`else
    exp_vec = 2'd0;
`endif
    n_total++;
    if (irq_req !== 1'b1 || irq_vec !== exp_vec)
      $display("FAIL prio_after_1: req=%b vec=%0d want 1/%0d", irq_req, irq_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_mask();
    do_reset();
    irq_mask_we = 1'b1; irq_mask_wdata = 4'b1110; tick(); irq_mask_we = 1'b0;
    irq_in = 4'b0001; tick(); irq_in = '0; tick(); tick();
    n_total++;
    if (irq_pending !== 4'b0001 || irq_req !== 1'b0)
      $display("FAIL mask_block: pending=%b req=%b want 0001/0", irq_pending, irq_req);
    else n_pass++;
    irq_mask_we = 1'b1; irq_mask_wdata = 4'b1111; tick(); irq_mask_we = 1'b0;
    n_total++;
    if (irq_req !== 1'b0) $display("FAIL mask_early: req=%b want 0", irq_req);
    else n_pass++;
    tick();
    n_total++;
    if (irq_req !== 1'b1 || irq_vec !== 2'd0)
      $display("FAIL mask_enable: req=%b vec=%0d want 1/0", irq_req, irq_vec);
    else n_pass++;
  endtask

  task automatic test_sleep();
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    n_total++;
    if (sleep_request !== 1'b0) $display("FAIL sleep_early: sleep_request=%b want 0", sleep_request);
    else n_pass++;
    tick();
    n_total++;
    if (sleep_request !== 1'b1) $display("FAIL sleep_timeout: sleep_request=%b want 1", sleep_request);
    else n_pass++;
    cpu_asleep = 1'b1; tick();
    n_total++;
    if (sleep_request !== 1'b0 || wakeup_request !== 1'b0)
      $display("FAIL sleep_enter: sleep=%b wake=%b want 0/0", sleep_request, wakeup_request);
    else n_pass++;
    irq_in = 4'b0010; tick(); irq_in = '0; tick();
    n_total++;
    if (wakeup_request !== 1'b1 || irq_req !== 1'b0)
      $display("FAIL sleep_wake: wake=%b req=%b want 1/0", wakeup_request, irq_req);
    else n_pass++;
    cpu_asleep = 1'b0; tick();
    n_total++;
    if (wakeup_request !== 1'b0 || irq_req !== 1'b0)
      $display("FAIL sleep_exit: wake=%b req=%b want 0/0", wakeup_request, irq_req);
    else n_pass++;
    tick();
    n_total++;
    if (irq_req !== 1'b1 || irq_vec !== 2'd1)
      $display("FAIL sleep_irq: req=%b vec=%0d want 1/1", irq_req, irq_vec);
    else n_pass++;
  endtask

  task automatic test_sleep_abort();
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    irq_in = 4'b0001; tick(); irq_in = '0;
    n_total++;
    if (sleep_request !== 1'b1) $display("FAIL abort_pend: sleep_request=%b want 1", sleep_request);
    else n_pass++;
    // CPU reports asleep in the same cycle the pending source is seen
    cpu_asleep = 1'b1; tick();
    n_total++;
    if (sleep_request !== 1'b0 || irq_req !== 1'b0)
      $display("FAIL abort_drop: sleep=%b req=%b want 0/0", sleep_request, irq_req);
    else n_pass++;
    tick();
    n_total++;
    if (irq_req !== 1'b1 || irq_vec !== 2'd0 || wakeup_request !== 1'b0)
      $display("FAIL abort_req: req=%b vec=%0d wake=%b want 1/0/0", irq_req, irq_vec, wakeup_request);
    else n_pass++;
    cpu_asleep = 1'b0;
  endtask

  task automatic test_stray();
    do_reset();
    irq_ack = 1'b1; irq_done = 1'b1; tick(); tick();
    irq_ack = 1'b0; irq_done = 1'b0;
    n_total++;
    if (irq_req !== 1'b0 || busy !== 1'b0 || irq_pending !== 4'b0000)
      $display("FAIL stray_idle: req=%b busy=%b pending=%b want 0/0/0000", irq_req, busy, irq_pending);
    else n_pass++;
  endtask

  task automatic test_reset_mid_service();
    do_reset();
    irq_in = 4'b1010; tick(); irq_in = '0; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 4'b0010; tick(); irq_in = '0;
    n_total++;
    if (busy !== 1'b1 || irq_pending !== 4'b1010)
      $display("FAIL midsvc_state: busy=%b pending=%b want 1/1010", busy, irq_pending);
    else n_pass++;
    reset = 1'b1; tick(); reset = 1'b0;
    n_total++;
    if ({irq_req, irq_vec, irq_pending, busy, sleep_request, wakeup_request} !== 10'b0)
      $display("FAIL midsvc_reset: got %b want 0", {irq_req, irq_vec, irq_pending, busy, sleep_request, wakeup_request});
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_sleep();
    test_sleep_abort();
    test_stray();
    test_reset_mid_service();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
